// File: rtl/v3_rob_pkg.sv
// Shared tag type and tag-memory reset convention for the ROB tag free list.
package v3_rob_pkg;

    localparam int unsigned P_NUM_ENTRIES = 8;
    localparam int unsigned TAG_W         = $clog2(P_NUM_ENTRIES);

    typedef logic [TAG_W-1:0] tag_t;

    // Tag memory resets to identity contents: entry i holds tag i.
    localparam bit TAG_MEM_RESET_IDENTITY = 1'b1;

endpackage

// File: rtl/v3_wrap_incr.sv
// Pointer increment that wraps at p_num_entries-1; works for non-power-of-2 depths.
module v3_wrap_incr #(
    parameter int unsigned p_num_entries = 8,
    parameter int unsigned p_width       = $clog2(p_num_entries)
) (
    input  logic [p_width-1:0] i_ptr,
    output logic [p_width-1:0] o_next_c
);

    always_comb begin
        o_next_c = i_ptr + p_width'(1);
        if (i_ptr == p_width'(p_num_entries - 1)) begin
            o_next_c = '0;
        end
    end

endmodule

// File: rtl/rob_tag_freelist_ctrl.sv
// Circular free list of ROB tags held in an external 1R/1W tag memory:
// allocation reads at head, frees write at tail, plus double-free detection.
module rob_tag_freelist_ctrl
    import v3_rob_pkg::*;
#(
    parameter int unsigned p_num_entries = P_NUM_ENTRIES,
    parameter int unsigned p_tag_width   = $clog2(p_num_entries),
    parameter int unsigned p_cnt_width   = $clog2(p_num_entries + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   alloc_val,
    input  logic                   alloc_rdy,
    output logic [p_tag_width-1:0] alloc_tag,
    input  logic                   free_val,
    output logic                   free_rdy,
    input  logic [p_tag_width-1:0] free_tag,
    output logic                   mem_write_en,
    output logic [p_tag_width-1:0] mem_write_addr,
    output logic [p_tag_width-1:0] mem_write_data,
    output logic                   mem_read_en,
    output logic [p_tag_width-1:0] mem_read_addr,
    input  logic [p_tag_width-1:0] mem_read_data,
    output logic [p_cnt_width-1:0] count,
    output logic                   err_double_free
);

    logic [p_tag_width-1:0]   r_head;
    logic [p_tag_width-1:0]   r_tail;
    logic [p_cnt_width-1:0]   r_count;
    logic [p_num_entries-1:0] r_in_use;
    logic                     r_err;

    logic [p_tag_width-1:0]   w_head_next;
    logic [p_tag_width-1:0]   w_tail_next;
    logic [p_cnt_width-1:0]   w_count_next;
    logic [p_num_entries-1:0] w_alloc_mask;
    logic [p_num_entries-1:0] w_free_mask;
    logic                     w_alloc_fire;
    logic                     w_free_fire;
    logic                     w_free_in_use;

    // Handshakes are forced idle while reset is asserted.
    assign alloc_val       = ~reset & (r_count != '0);
    assign free_rdy        = ~reset & (r_count != p_cnt_width'(p_num_entries));
    assign w_alloc_fire    = alloc_val & alloc_rdy;
    assign w_free_fire     = free_val & free_rdy;

    assign mem_read_en     = alloc_val;
    assign mem_read_addr   = r_head;
    assign alloc_tag       = mem_read_data;

    assign mem_write_en    = w_free_fire;
    assign mem_write_addr  = r_tail;
    assign mem_write_data  = free_tag;

    assign count           = r_count;
    assign err_double_free = ~reset & r_err;

    v3_wrap_incr #(
        .p_num_entries (p_num_entries),
        .p_width       (p_tag_width)
    ) u_head_incr (
        .i_ptr    (r_head),
        .o_next_c (w_head_next)
    );

    v3_wrap_incr #(
        .p_num_entries (p_num_entries),
        .p_width       (p_tag_width)
    ) u_tail_incr (
        .i_ptr    (r_tail),
        .o_next_c (w_tail_next)
    );

    // One-hot set/clear masks into the in-use vector.
    always_comb begin
        w_alloc_mask = '0;
        w_free_mask  = '0;
        for (int unsigned i = 0; i < p_num_entries; i++) begin
            w_alloc_mask[i] = w_alloc_fire && (alloc_tag == p_tag_width'(i));
            w_free_mask[i]  = w_free_fire && (free_tag == p_tag_width'(i));
        end
        w_free_in_use = |(r_in_use & w_free_mask);
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_alloc_fire, w_free_fire})
            2'b10:   w_count_next = r_count - p_cnt_width'(1);
            2'b01:   w_count_next = r_count + p_cnt_width'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= p_cnt_width'(p_num_entries);
            r_in_use <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_alloc_fire) begin
                r_head <= w_head_next;
            end
            if (w_free_fire) begin
                r_tail <= w_tail_next;
            end
            r_count  <= w_count_next;
            r_in_use <= (r_in_use | w_alloc_mask) & ~w_free_mask;
            r_err    <= r_err | (w_free_fire & ~w_free_in_use);
        end
    end

endmodule

// File: doc/rob_tag_freelist_ctrl.md
Name: rob_tag_freelist_ctrl

Overview:
- Controller that manages ROB/physical tags as a circular FIFO stored in an external 1-read/1-write tag memory.
- The memory resets to identity contents (entry i holds tag i), so the free list starts full with tags 0..N-1 in order.
- This block is the initiator on the memory's ports: it drives read/write enables and addresses from head/tail pointers.
- It exposes an allocate port toward dispatch and a free port toward commit, plus occupancy and error status.

Parameters:
- p_num_entries, 8, number of tags and memory entries; any value ≥ 2, not necessarily a power of 2.
- p_tag_width, $clog2(p_num_entries), width of a tag; also the memory address and data width.
- p_cnt_width, $clog2(p_num_entries+1), width of the occupancy counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- alloc_val  out  1  a free tag is available
- alloc_rdy  in  1  consumer takes the tag this cycle
- alloc_tag  out  p_tag_width  tag offered; valid only while alloc_val=1
- free_val  in  1  a tag is being returned
- free_rdy  out  1  free list can accept a tag
- free_tag  in  p_tag_width  tag being returned
- mem_write_en  out  1  memory write enable
- mem_write_addr  out  p_tag_width  memory write address (tail)
- mem_write_data  out  p_tag_width  memory write data
- mem_read_en  out  1  memory read enable
- mem_read_addr  out  p_tag_width  memory read address (head)
- mem_read_data  in  p_tag_width  combinational memory read data
- count  out  p_cnt_width  number of free tags
- err_double_free  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. Reset has priority over all other activity.
- Outputs while reset=1: alloc_val=0, free_rdy=0, mem_write_en=0, mem_read_en=0, err_double_free=0.
- State after reset: head=0, tail=0, count=p_num_entries, in_use vector all 0. The memory shares the same reset, so its contents become identity in the same cycle.
- Allocate handshake:
  - alloc_val = (count != 0).
  - mem_read_en = alloc_val; mem_read_addr = head.
  - alloc_tag = mem_read_data, combinational, so latency is 0 cycles.
  - A fire occurs when alloc_val & alloc_rdy: head advances, count decrements, and in_use[alloc_tag] is set at the clock edge.
  - alloc_tag is stable for as long as alloc_val=1 and no fire occurs.
- Free handshake:
  - free_rdy = (count != p_num_entries).
  - A fire occurs when free_val & free_rdy: mem_write_en=1, mem_write_addr=tail, mem_write_data=free_tag; tail advances, count increments, in_use[free_tag] is cleared.
  - With free_rdy=0, mem_write_en is 0 and no state changes.
- Pointer wrap: a pointer at p_num_entries-1 advances to 0; otherwise it increments by 1. There is no modulo-2^n assumption.
- Simultaneous alloc fire and free fire:
  - Both pointers advance and count is unchanged.
  - The memory read (head) and write (tail) are independent.
  - head==tail with count in 1..N-1 is impossible, so no read/write collision occurs.
- Empty (count=0): alloc_val=0. A free in the same cycle is accepted but not bypassed; the tag becomes allocatable on the next cycle.
- Full (count=N): free_rdy=0 even if an alloc fires in the same cycle; there is no pass-through.
- Double-free: a free fire with in_use[free_tag]=0 sets err_double_free=1. The flag stays set until reset. The write is still performed and count still increments.
- Reset mid-operation: outstanding allocations are discarded; the next alloc after reset returns tag 0.
- Registered state: head, tail, count, in_use, err_double_free. Everything else is combinational.

Decomposition:
- Package v3_rob_pkg holds the tag_t typedef, derived from p_num_entries (default 8), and the identity-reset convention constant.
- Natural sub-module: v3_wrap_incr, a parameterized pointer increment with wrap at p_num_entries-1. It is instantiated twice, for head and tail.
- The tag memory is instantiated by the parent and wired to the mem_* ports.

Test Plan:
- Reset, then alloc_rdy=1 for 8 cycles (N=8) -> tags 0,1,...,7 in order, count 8→0, then alloc_val=0 and mem_read_en=0.
- After draining: free tag 5, then tag 2, then alloc twice -> alloc_tag=5, then 2; mem_write_addr=0, then 1.
- count=3, alloc and free (tag 6) fire in the same cycle -> count stays 3, mem_write_en=1 at tail, head advances, no error.
- Right after reset (count=8): free_val=1 with tag 3 -> free_rdy=0, mem_write_en=0, count stays 8, err_double_free stays 0.
- Allocate tags 0–2, free tag 1, then free tag 1 again -> err_double_free=1 on the second free and it stays 1. Then reset -> error flag 0, count=8, next alloc_tag=0.
- N=6: 6 allocs, 6 frees, 6 allocs -> head and tail wrap 5→0, second allocation sequence returns the tags in the order they were freed.
